// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing constants and the phase encoding used by
// both the horizontal and vertical sequencers.
package vga_timing_pkg;

  localparam int CLK_DIV  = 4;
  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    FRONT  = 2'd1,
    SYNC   = 2'd2,
    BACK   = 2'd3
  } timing_state_t;

  // Advance one phase when the upcoming count hits that phase's first value.
  function automatic timing_state_t step_state(
    input timing_state_t cur,
    input logic [9:0]    cnt_next,
    input logic [9:0]    front_at,
    input logic [9:0]    sync_at,
    input logic [9:0]    back_at
  );
    timing_state_t nxt;
    nxt = cur;
    case (cur)
      ACTIVE:  if (cnt_next == front_at) nxt = FRONT;
      FRONT:   if (cnt_next == sync_at)  nxt = SYNC;
      SYNC:    if (cnt_next == back_at)  nxt = BACK;
      BACK:    if (cnt_next == 10'd0)    nxt = ACTIVE;
      default: nxt = ACTIVE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/divisor_pixel.sv
// Board-clock divider producing the pixel-rate enable, high while the
// counter sits on its last value.
module divisor_pixel #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] div_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
    end else if (div_cnt == CNT_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CNT_W'(1);
    end
  end

  assign tick = (div_cnt == CNT_LAST);

endmodule

// File: rtl/sincronizacion_vga.sv
// VGA timing generator: pixel/line counters, H/V phase sequencers and
// registered sync, blanking and marker outputs aligned to X/Y.
module sincronizacion_vga #(
  parameter int CLK_DIV  = vga_timing_pkg::CLK_DIV,
  parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int H_FP     = vga_timing_pkg::H_FP,
  parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int H_BP     = vga_timing_pkg::H_BP,
  parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int V_FP     = vga_timing_pkg::V_FP,
  parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int V_BP     = vga_timing_pkg::V_BP
) (
  input  logic       clk,
  input  logic       reset,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       pixel_tick,
  output logic [9:0] X,
  output logic [9:0] Y,
  output logic       line_end,
  output logic       frame_start
);

  import vga_timing_pkg::*;

  localparam logic [9:0] X_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] X_FRONT = 10'(H_ACTIVE);
  localparam logic [9:0] X_SYNC  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] X_BACK  = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] Y_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] Y_FRONT = 10'(V_ACTIVE);
  localparam logic [9:0] Y_SYNC  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] Y_BACK  = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic          tick_next;
  logic [9:0]    x_next;
  logic [9:0]    y_next;
  timing_state_t h_state;
  timing_state_t h_state_next;
  timing_state_t v_state;
  timing_state_t v_state_next;

  divisor_pixel #(
    .CLK_DIV(CLK_DIV)
  ) u_divisor_pixel (
    .clk  (clk),
    .reset(reset),
    .tick (tick_next)
  );

  always_comb begin
    x_next = X;
    y_next = Y;
    if (tick_next) begin
      if (X == X_LAST) begin
        x_next = '0;
        y_next = (Y == Y_LAST) ? 10'd0 : Y + 10'd1;
      end else begin
        x_next = X + 10'd1;
      end
    end
  end

  // Reset parks both sequencers in BACK to match the last-position counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_state <= BACK;
      v_state <= BACK;
    end else begin
      h_state <= h_state_next;
      v_state <= v_state_next;
    end
  end

  always_comb begin
    h_state_next = step_state(h_state, x_next, X_FRONT, X_SYNC, X_BACK);
    v_state_next = step_state(v_state, y_next, Y_FRONT, Y_SYNC, Y_BACK);
  end

  // Outputs decode the next phase so they change on the same edge as X/Y.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      X           <= X_LAST;
      Y           <= Y_LAST;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      video_on    <= 1'b0;
      pixel_tick  <= 1'b0;
      line_end    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      X           <= x_next;
      Y           <= y_next;
      hsync       <= (h_state_next != SYNC);
      vsync       <= (v_state_next != SYNC);
      video_on    <= (h_state_next == ACTIVE) && (v_state_next == ACTIVE);
      pixel_tick  <= tick_next;
      line_end    <= tick_next && (X == X_LAST);
      frame_start <= tick_next && (X == X_LAST) && (Y == Y_LAST);
    end
  end

endmodule

// File: tb/tb_sincronizacion_vga.sv
// Directed bench: full-size generator for reset, cadence, line and mid-frame
// reset; a shrunken-timing instance for whole-frame vertical behaviour.
module tb_sincronizacion_vga;

  logic       clk = 1'b0;
  logic       reset;
  logic       reset_s;

  logic       hsync, vsync, video_on, pixel_tick, line_end, frame_start;
  logic [9:0] X, Y;
  logic       hsync_s, vsync_s, video_on_s, pixel_tick_s, line_end_s, frame_start_s;
  logic [9:0] X_s, Y_s;

  int n_checks = 0;
  int n_fail   = 0;

  int n, found, exp_x, last_x, seq_err, vid_err, hs_cnt, hs_first, hs_last;
  int le_cnt, le_prev_x, vid_fall_x, started, fr_ticks, vs_cnt, vs_bad_y;
  int vid_cnt, hs_s_cnt, prev_x, prev_y, wrap_le, wrap_x, wrap_y;

  always #5 clk = ~clk;

  sincronizacion_vga dut (
    .clk        (clk),
    .reset      (reset),
    .hsync      (hsync),
    .vsync      (vsync),
    .video_on   (video_on),
    .pixel_tick (pixel_tick),
    .X          (X),
    .Y          (Y),
    .line_end   (line_end),
    .frame_start(frame_start)
  );

  // H_TOTAL=15 (sync X 10..12), V_TOTAL=8 (sync Y 5..6), CLK_DIV=2.
  sincronizacion_vga #(
    .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut_s (
    .clk        (clk),
    .reset      (reset_s),
    .hsync      (hsync_s),
    .vsync      (vsync_s),
    .video_on   (video_on_s),
    .pixel_tick (pixel_tick_s),
    .X          (X_s),
    .Y          (Y_s),
    .line_end   (line_end_s),
    .frame_start(frame_start_s)
  );

  task automatic checkOutput(input string tag, input int observed, input int expected);
    n_checks++;
    assert (observed === expected)
      else begin
        n_fail++;
        $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_x"}, X, 799);
    checkOutput({tag, "_y"}, Y, 524);
    checkOutput({tag, "_hsync"}, hsync, 1);
    checkOutput({tag, "_vsync"}, vsync, 1);
    checkOutput({tag, "_video_on"}, video_on, 0);
    checkOutput({tag, "_pixel_tick"}, pixel_tick, 0);
    checkOutput({tag, "_line_end"}, line_end, 0);
    checkOutput({tag, "_frame_start"}, frame_start, 0);
  endtask

  task automatic checkFirstTick(input string tag);
    repeat (3) @(negedge clk);
    checkOutput({tag, "_no_early_tick"}, pixel_tick, 0);
    @(negedge clk);
    checkOutput({tag, "_tick"}, pixel_tick, 1);
    checkOutput({tag, "_x0"}, X, 0);
    checkOutput({tag, "_y0"}, Y, 0);
    checkOutput({tag, "_video_on"}, video_on, 1);
    checkOutput({tag, "_frame_start"}, frame_start, 1);
    checkOutput({tag, "_line_end"}, line_end, 1);
    checkOutput({tag, "_hsync"}, hsync, 1);
  endtask

  initial begin
    $display("[TB] start");
    reset   = 1'b0;
    reset_s = 1'b0;
    repeat (5) @(negedge clk);
    checkResetState("reset");
    checkOutput("reset_s_x", X_s, 14);
    checkOutput("reset_s_y", Y_s, 7);

    reset   = 1'b1;
    reset_s = 1'b1;
    checkFirstTick("first");

    @(negedge clk);
    checkOutput("pulse_width_tick", pixel_tick, 0);
    checkOutput("pulse_width_frame", frame_start, 0);
    checkOutput("hold_x", X, 0);
    n = 1;
    while (n < 10 && !pixel_tick) begin
      @(negedge clk);
      n++;
    end
    checkOutput("tick_period_div4", n, 4);
    checkOutput("second_x", X, 1);

    $display("[TB] horizontal line scan");
    exp_x = 1; last_x = 1; seq_err = 0; vid_err = 0; hs_cnt = 0;
    hs_first = -1; hs_last = -1; le_cnt = 0; le_prev_x = -1; vid_fall_x = -1;
    found = 0;
    for (int j = 0; j < 4000 && !found; j++) begin
      @(negedge clk);
      if (pixel_tick) begin
        exp_x = (exp_x == 799) ? 0 : exp_x + 1;
        if (X !== 10'(exp_x)) seq_err++;
        if (!hsync) begin
          hs_cnt++;
          if (hs_first < 0) hs_first = X;
          hs_last = X;
        end
        if (video_on !== (X < 640)) vid_err++;
        if (!video_on && vid_fall_x < 0) vid_fall_x = X;
        if (line_end) begin
          le_cnt++;
          le_prev_x = last_x;
        end
        last_x = X;
        if (X == 0) found = 1;
      end
    end
    checkOutput("line_wrap_reached", found, 1);
    checkOutput("x_sequence_errors", seq_err, 0);
    checkOutput("video_on_errors", vid_err, 0);
    checkOutput("video_on_fall_x", vid_fall_x, 640);
    checkOutput("hsync_low_ticks", hs_cnt, 96);
    checkOutput("hsync_first_x", hs_first, 656);
    checkOutput("hsync_last_x", hs_last, 751);
    checkOutput("line_end_count", le_cnt, 1);
    checkOutput("line_end_from_x", le_prev_x, 799);
    checkOutput("line_wrap_y", Y, 1);
    checkOutput("line_wrap_frame_start", frame_start, 0);

    n = 0;
    while (n < 10 && !pixel_tick_s) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (n < 10 && !pixel_tick_s);
    checkOutput("tick_period_div2", n, 2);

    $display("[TB] mid-frame reset");
    found = 0;
    for (int k = 0; k < 4000 && !found; k++) begin
      @(negedge clk);
      if (X == 700) found = 1;
    end
    checkOutput("reach_x700", found, 1);
    checkOutput("x700_hsync_low", hsync, 0);
    #2 reset = 1'b0;
    #1 checkResetState("midreset");
    @(negedge clk);
    checkResetState("midreset_hold");
    reset = 1'b1;
    checkFirstTick("restart");

    $display("[TB] small-timing frame");
    reset_s = 1'b0;
    repeat (3) @(negedge clk);
    reset_s = 1'b1;
    started = 0; fr_ticks = 0; vs_cnt = 0; vs_bad_y = 0; vid_cnt = 0; hs_s_cnt = 0;
    prev_x = -1; prev_y = -1; wrap_le = -1; wrap_x = -1; wrap_y = -1; found = 0;
    for (int f = 0; f < 600 && !found; f++) begin
      @(negedge clk);
      if (pixel_tick_s) begin
        if (frame_start_s && started) begin
          found   = 1;
          wrap_le = line_end_s;
          wrap_x  = X_s;
          wrap_y  = Y_s;
        end else begin
          started = 1;
          fr_ticks++;
          if (!vsync_s) begin
            vs_cnt++;
            if (Y_s != 5 && Y_s != 6) vs_bad_y++;
          end
          if (!hsync_s) hs_s_cnt++;
          if (video_on_s) vid_cnt++;
          prev_x = X_s;
          prev_y = Y_s;
        end
      end
    end
    checkOutput("frame_wrap_reached", found, 1);
    checkOutput("frame_ticks", fr_ticks, 120);
    checkOutput("vsync_low_ticks", vs_cnt, 30);
    checkOutput("vsync_bad_y", vs_bad_y, 0);
    checkOutput("hsync_low_ticks_frame", hs_s_cnt, 24);
    checkOutput("video_on_ticks", vid_cnt, 32);
    checkOutput("pre_wrap_x", prev_x, 14);
    checkOutput("pre_wrap_y", prev_y, 7);
    checkOutput("wrap_line_end", wrap_le, 1);
    checkOutput("wrap_x", wrap_x, 0);
    checkOutput("wrap_y", wrap_y, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
